dpram_fifo_ctrl: RTL and testbench

Synchronous FIFO controller that sits directly upstream of the DPRAM and drives its write and read ports (`wr_address`, `write`, `data_in`, `rd_address`, `read`). It converts a push/pop stream interface into circular-buffer addressing over the RAM. It maintains full/empty/occupancy state and flags when DPRAM read data is valid. Data storage stays in the DPRAM; this block holds only pointers and flags.

---
 rtl/dpram_fifo_ctrl_if.sv | 38 +++
 rtl/dpram_fifo_ctrl.sv | 104 ++++++++++
 tb/tb_dpram_fifo_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/dpram_fifo_ctrl_if.sv
// Push/pop stream interface for dpram_fifo_ctrl.
// The optional error outputs exist only when FIFO_ERR_FLAGS_EN is defined.
// Handshake: a push is taken on a rising edge when push=1 and full=0; a pop is
// taken on a rising edge when pop=1 and empty=0. Requests made while full or
// empty are dropped, and the requester may hold or change them freely.
// The popped word is on the DPRAM output in the cycle where rd_valid=1.
interface dpram_fifo_ctrl_if #(
  parameter int RAM_WIDTH = 8,
  parameter int ADDR_SZ   = 4
);
  logic                 push;
  logic [RAM_WIDTH-1:0] push_data;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [ADDR_SZ:0]     count;
  logic                 rd_valid;
`ifdef FIFO_ERR_FLAGS_EN
  logic                 overflow;
  logic                 underflow;
`endif

  modport master (
    output push, push_data, pop,
`ifdef FIFO_ERR_FLAGS_EN
    input  overflow, underflow,
`endif
    input  full, empty, count, rd_valid
  );

  modport slave (
    input  push, push_data, pop,
`ifdef FIFO_ERR_FLAGS_EN
    output overflow, underflow,
`endif
    output full, empty, count, rd_valid
  );
endinterface

// File: rtl/dpram_fifo_ctrl.sv
// Circular-buffer FIFO controller driving the write and read ports of an
// external DPRAM. This block holds only the pointers and the status flags.
// Optional feature macro: FIFO_ERR_FLAGS_EN adds sticky overflow/underflow flags.
module dpram_fifo_ctrl #(
  parameter int RAM_WIDTH = 8,
  parameter int RAM_DEPTH = 16,
  parameter int ADDR_SZ   = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  dpram_fifo_ctrl_if.slave     fifo,
  output logic [ADDR_SZ-1:0]   wr_address,
  output logic                 write,
  output logic [RAM_WIDTH-1:0] data_in,
  output logic [ADDR_SZ-1:0]   rd_address,
  output logic                 read
);

  localparam logic [ADDR_SZ:0] DEPTH_CNT = (ADDR_SZ+1)'(RAM_DEPTH);

  // Pointers carry one extra wrap bit so that full and empty can be told apart.
  logic [ADDR_SZ:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_SZ:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_SZ:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             rd_valid_q, rd_valid_d;

  // Accept requests against the current flags and drive the RAM ports.
  always_comb begin
    write      = fifo.push & ~full_q;
    read       = fifo.pop & ~empty_q;
    data_in    = fifo.push_data;
    wr_address = wr_ptr_q[ADDR_SZ-1:0];
    rd_address = rd_ptr_q[ADDR_SZ-1:0];
  end

  // Advance the pointers and derive flags from the post-edge pointer values.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + {{ADDR_SZ{1'b0}}, write};
    rd_ptr_d   = rd_ptr_q + {{ADDR_SZ{1'b0}}, read};
    count_d    = wr_ptr_d - rd_ptr_d;
    empty_d    = (wr_ptr_d == rd_ptr_d);
    // Occupancy equals depth exactly when low bits match and wrap bits differ.
    full_d     = (count_d == DEPTH_CNT);
    rd_valid_d = read;
  end

  // Pointer and flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Status outputs straight from the registers.
  always_comb begin
    fifo.full     = full_q;
    fifo.empty    = empty_q;
    fifo.count    = count_q;
    fifo.rd_valid = rd_valid_q;
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error flags: set on any rejected request, cleared only by reset.
  always_comb begin
    overflow_d  = overflow_q | (fifo.push & full_q);
    underflow_d = underflow_q | (fifo.pop & empty_q);
  end

  // Error flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Error flag outputs.
  always_comb begin
    fifo.overflow  = overflow_q;
    fifo.underflow = underflow_q;
  end
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Self-checking bench for dpram_fifo_ctrl with a behavioural DPRAM and a
// queue-based FIFO reference model.
module tb_dpram_fifo_ctrl;

  localparam int W     = 8;
  localparam int A     = 4;
  localparam int DEPTH = 16;

  // Clock and reset
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  dpram_fifo_ctrl_if #(.RAM_WIDTH(W), .ADDR_SZ(A)) fifo_if ();

  logic [A-1:0] wr_address;
  logic         write;
  logic [W-1:0] data_in;
  logic [A-1:0] rd_address;
  logic         read;

  dpram_fifo_ctrl #(.RAM_WIDTH(W), .RAM_DEPTH(DEPTH), .ADDR_SZ(A)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .fifo       (fifo_if.slave),
    .wr_address (wr_address),
    .write      (write),
    .data_in    (data_in),
    .rd_address (rd_address),
    .read       (read)
  );

  // Behavioural DPRAM: registered read, one-cycle latency.
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] data_out;
  always @(posedge clk) begin
    if (write) mem[wr_address] <= data_in;
    if (read)  data_out <= mem[rd_address];
  end

  // Reference model and scoreboard
  logic [W-1:0] exp_q[$];
  int           wr_idx;
  int           rd_idx;
  logic [W-1:0] exp_rd_data;
  bit           exp_rd_valid;
  bit           exp_ovf;
  bit           exp_udf;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    wr_idx       = 0;
    rd_idx       = 0;
    exp_rd_valid = 0;
    exp_ovf      = 0;
    exp_udf      = 0;
  endtask

  task automatic check_status();
    check("count", 32'(fifo_if.count), 32'(exp_q.size()));
    check("full", 32'(fifo_if.full), 32'(exp_q.size() == DEPTH));
    check("empty", 32'(fifo_if.empty), 32'(exp_q.size() == 0));
    check("rd_valid", 32'(fifo_if.rd_valid), 32'(exp_rd_valid));
`ifdef FIFO_ERR_FLAGS_EN
    check("overflow", 32'(fifo_if.overflow), 32'(exp_ovf));
    check("underflow", 32'(fifo_if.underflow), 32'(exp_udf));
`endif
  endtask

  // Driver: one clock cycle with the given request pattern.
  task automatic step(input bit p, input logic [W-1:0] d, input bit o);
    bit acc_w, acc_r;
    @(negedge clk);
    fifo_if.push      = p;
    fifo_if.push_data = d;
    fifo_if.pop       = o;
    #1;
    acc_w = p && (exp_q.size() < DEPTH);
    acc_r = o && (exp_q.size() > 0);
    check("write", 32'(write), 32'(acc_w));
    check("read", 32'(read), 32'(acc_r));
    check("wr_address", 32'(wr_address), 32'(wr_idx % DEPTH));
    check("rd_address", 32'(rd_address), 32'(rd_idx % DEPTH));
    check("data_in", 32'(data_in), 32'(d));
    @(posedge clk);
    #1;
    if (acc_r) begin
      exp_rd_data = exp_q.pop_front();
      rd_idx++;
    end
    if (acc_w) begin
      exp_q.push_back(d);
      wr_idx++;
    end
    exp_rd_valid = acc_r;
    if (p && !acc_w) exp_ovf = 1;
    if (o && !acc_r) exp_udf = 1;
    check_status();
    if (exp_rd_valid) check("rd_data", 32'(data_out), 32'(exp_rd_data));
  endtask

  initial begin
    fifo_if.push      = 1'b0;
    fifo_if.push_data = '0;
    fifo_if.pop       = 1'b0;
    reset_n           = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check_status();
    check("rst_write", 32'(write), 32'(0));
    check("rst_read", 32'(read), 32'(0));
    check("rst_wr_address", 32'(wr_address), 32'(0));
    check("rst_rd_address", 32'(rd_address), 32'(0));
    @(negedge clk);
    reset_n = 1'b1;

    // Fill with 0xFF down to 0xF0, then one rejected push
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'hFF - i), 1'b0);
    step(1'b1, 8'hAA, 1'b0);

    // Drain in order, then one rejected pop
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Hold 8 words then stream push+pop across the address wrap
    for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b1);

    // Fill to full, then push and pop together: only the pop is taken
    while (exp_q.size() < DEPTH) step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    step(1'b1, 8'h5A, 1'b1);
    step(1'b1, 8'hA5, 1'b0);

    // Bring occupancy to 5 and reset while a pop is being accepted
    while (exp_q.size() > 5) step(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    fifo_if.push = 1'b0;
    fifo_if.pop  = 1'b1;
    #1;
    check("pre_reset_read", 32'(read), 32'(1));
    #1;
    reset_n = 1'b0;
    #1;
    model_clear();
    check_status();
    check("reset_read", 32'(read), 32'(0));
    @(negedge clk);
    fifo_if.pop = 1'b0;
    reset_n     = 1'b1;
    step(1'b1, 8'h3C, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    while (exp_q.size() > 0) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
